// File: rtl/shift_exec_unit.sv
// Multi-cycle MIPS shift unit (sll/srl/sra and variable forms).
// Shifts at most STEP bits per cycle and reports one done pulse per op.
//
// Parameter:
//   STEP        max bits shifted per SHIFT cycle (1, 2, 4, 8 or 16)
// Ports:
//   CLK         rising-edge clock
//   reset       asynchronous active-low reset
//   start       issue request, sampled only while busy=0
//   funct       R-type funct field selecting the shift kind
//   rt_data     operand to be shifted
//   rs_data     variable shift amount source (bits [4:0] only)
//   shamt       immediate shift amount
//   rd          destination register number
//   busy        operation in flight (SHIFT or DONE)
//   done        one-cycle completion pulse
//   result      shifted value, held until the next done
//   wr_reg      captured rd, held until the next done
//   wr_en       register write strobe for a supported funct
//   invalid_op  completion flag for an unsupported funct
module shift_exec_unit #(
    parameter int STEP = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] rt_data,
    input  logic [31:0] rs_data,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wr_reg,
    output logic        wr_en,
    output logic        invalid_op
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2
    } op_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      state_q;
    state_t      state_d;
    op_t         op_q;
    logic        valid_q;
    logic [31:0] work_q;
    logic [4:0]  rem_q;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic [4:0]  wr_reg_q;

    op_t         dec_op;
    logic        dec_valid;
    logic [4:0]  dec_amt;
    logic [4:0]  cnt;
    logic [4:0]  rem_nxt;
    logic [31:0] shifted;

    // Only the low five bits of rs select the amount.
    logic unused_rs;
    assign unused_rs = ^rs_data[31:5];

    // funct[2] distinguishes the variable forms from the shamt forms.
    always_comb begin
        dec_valid = 1'b1;
        dec_op    = OP_SLL;
        case (funct)
            6'b000000, 6'b000100: dec_op = OP_SLL;
            6'b000010, 6'b000110: dec_op = OP_SRL;
            6'b000011, 6'b000111: dec_op = OP_SRA;
            default:              dec_valid = 1'b0;
        endcase
        dec_amt = funct[2] ? rs_data[4:0] : shamt;
    end

    // Shift by min(remaining, STEP) this cycle.
    always_comb begin
        cnt     = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        rem_nxt = rem_q - cnt;
        case (op_q)
            OP_SLL:  shifted = work_q << cnt;
            OP_SRL:  shifted = work_q >> cnt;
            OP_SRA:  shifted = 32'($signed(work_q) >>> cnt);
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dec_valid && (dec_amt != 5'd0))
                        state_d = SHIFT;
                    else
                        state_d = DONE;
                end
            end
            SHIFT: begin
                if (rem_nxt == 5'd0)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= OP_SLL;
            valid_q  <= 1'b0;
            work_q   <= 32'd0;
            rem_q    <= 5'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            wr_reg_q <= 5'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= rt_data;
                        rem_q   <= dec_valid ? dec_amt : 5'd0;
                        op_q    <= dec_op;
                        valid_q <= dec_valid;
                        rd_q    <= rd;
                        // Zero-amount and invalid ops skip SHIFT, so
                        // the visible result is loaded here.
                        if (state_d == DONE) begin
                            result_q <= dec_valid ? rt_data : 32'd0;
                            wr_reg_q <= rd;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shifted;
                    rem_q  <= rem_nxt;
                    if (rem_nxt == 5'd0) begin
                        result_q <= shifted;
                        wr_reg_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign wr_en      = done && valid_q;
    assign invalid_op = done && !valid_q;
    assign result     = result_q;
    assign wr_reg     = wr_reg_q;

endmodule
